// File: rtl/lab4_pkg.sv
// Shared types and display constants for the one-digit 2-bit counter.
// Segment vectors are listed a..g from left to right, active-low.
package lab4_pkg;

    typedef logic [1:0] count_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] AN_DIGIT0 = 8'b1111_1110;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 2-bit value to active-low seven-segment pattern.
// Output bit 0 is segment a, bit 6 is segment g.
module seg7_decoder
    import lab4_pkg::*;
(
    input  count_t     value,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            2'd0:    seg = SEG_0;
            2'd1:    seg = SEG_1;
            2'd2:    seg = SEG_2;
            2'd3:    seg = SEG_3;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lab4_part4.sv
// Prescaled 2-bit counter shown on digit 0 of the seven-segment bank
// and mirrored on two LEDs.
module lab4_part4
    import lab4_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    output logic [0:6] HEX0,
    output logic [7:0] AN,
    output logic [1:0] LEDR
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;
    count_t        cnt_q;
    count_t        cnt_d;

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);
        cnt_d = tick ? cnt_q + 2'd1 : cnt_q;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    seg7_decoder u_dec (
        .value (cnt_q),
        .seg   (HEX0)
    );

    assign LEDR = cnt_q;
    assign AN   = AN_DIGIT0;

endmodule

// File: tb/tb_lab4_part4.sv
// Randomized self-checking bench for lab4_part4 with TICK_DIV=4,
// plus a default-divider instance that must stay at zero.
module tb_lab4_part4;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic [0:6] hex;
    logic [7:0] an;
    logic [1:0] ledr;
    logic [0:6] hex_b;
    logic [7:0] an_b;
    logic [1:0] ledr_b;

    int n_cmp;
    int n_bad;
    int n;

    logic [6:0] seg_tab [4];

    lab4_part4 #(.TICK_DIV(TD)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .HEX0       (hex),
        .AN         (an),
        .LEDR       (ledr)
    );

    lab4_part4 u_big (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .HEX0       (hex_b),
        .AN         (an_b),
        .LEDR       (ledr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of active edges since release sets the expected value.
    function automatic logic [1:0] exp_cnt(input int edges);
        return 2'((edges / TD) % 4);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        n = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (ledr !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_ledr cyc=%0d got=%b want=00", i, ledr);
            end
            n_cmp++;
            if (hex !== seg_tab[0]) begin
                n_bad++;
                $display("FAIL reset_hex cyc=%0d got=%b want=%b", i, hex, seg_tab[0]);
            end
            n_cmp++;
            if (an !== 8'b1111_1110) begin
                n_bad++;
                $display("FAIL reset_an cyc=%0d got=%b want=11111110", i, an);
            end
        end
    endtask

    task automatic test_counting();
        #3;
        rst_n = 1'b1;
        n = 0;
        for (int e = 1; e <= 16; e++) begin
            step();
            n_cmp++;
            if (ledr !== exp_cnt(n)) begin
                n_bad++;
                $display("FAIL count_ledr edge=%0d got=%0d want=%0d", e, ledr, exp_cnt(n));
            end
            n_cmp++;
            if (hex !== seg_tab[exp_cnt(n)]) begin
                n_bad++;
                $display("FAIL count_hex edge=%0d got=%b want=%b", e, hex, seg_tab[exp_cnt(n)]);
            end
            n_cmp++;
            if (an !== 8'b1111_1110) begin
                n_bad++;
                $display("FAIL count_an edge=%0d got=%b", e, an);
            end
        end
        n_cmp++;
        if (ledr !== 2'd0) begin
            n_bad++;
            $display("FAIL count_wrap got=%0d want=0", ledr);
        end
    endtask

    task automatic test_hold();
        logic [1:0] want;
        while (n % TD != 0) step();
        want = exp_cnt(n);
        for (int e = 1; e <= 3; e++) begin
            step();
            n_cmp++;
            if (ledr !== want || hex !== seg_tab[want]) begin
                n_bad++;
                $display("FAIL hold edge=%0d got=%0d/%b want=%0d/%b", e, ledr, hex, want, seg_tab[want]);
            end
        end
    endtask

    task automatic test_mid_reset();
        while (n % 16 != 10) step();
        n_cmp++;
        if (ledr !== 2'd2) begin
            n_bad++;
            $display("FAIL midrst_pre got=%0d want=2", ledr);
        end
        #2;
        rst_n = 1'b0;
        n = 0;
        #1;
        n_cmp++;
        if (ledr !== 2'd0 || hex !== seg_tab[0]) begin
            n_bad++;
            $display("FAIL midrst_clear got=%0d/%b want=0/%b", ledr, hex, seg_tab[0]);
        end
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_cmp++;
            if (ledr !== ((e == 4) ? 2'd1 : 2'd0)) begin
                n_bad++;
                $display("FAIL midrst_restart edge=%0d got=%0d want=%0d", e, ledr, (e == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                #($urandom_range(1, 3));
                rst_n = 1'b0;
                n = 0;
                #1;
                n_cmp++;
                if (ledr !== 2'd0 || hex !== seg_tab[0]) begin
                    n_bad++;
                    $display("FAIL rand_rst k=%0d got=%0d/%b want=0", k, ledr, hex);
                end
                #1;
                rst_n = 1'b1;
            end else begin
                step();
                n_cmp++;
                if (ledr !== exp_cnt(n) || hex !== seg_tab[exp_cnt(n)] || an !== 8'b1111_1110) begin
                    n_bad++;
                    $display("FAIL rand k=%0d n=%0d got=%0d/%b/%b want=%0d/%b/11111110", k, n, ledr, hex, an, exp_cnt(n), seg_tab[exp_cnt(n)]);
                end
            end
        end
    endtask

    task automatic test_default_param();
        n_cmp++;
        if (ledr_b !== 2'd0 || hex_b !== seg_tab[0] || an_b !== 8'b1111_1110) begin
            n_bad++;
            $display("FAIL default_div got=%0d/%b/%b want=0/%b/11111110", ledr_b, hex_b, an_b, seg_tab[0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n = 0;
        seg_tab[0] = 7'b0000001;
        seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110;
        test_reset();
        test_counting();
        test_hold();
        test_mid_reset();
        test_hold();
        test_random();
        test_default_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
